// File: rtl/picovid_pkg.sv
// Shared constants and types for the Pico video link capture path.
// Queue entries are {ub, lb, off[15:0], data[15:0]}; offsets below locate each field.
package picovid_pkg;

  localparam logic [3:0] HDR_TAG      = 4'hA;
  localparam int         FRAME_BYTES  = 5;
  localparam logic [6:0] DEF_WIN_BASE = 7'h70;

  localparam int ENT_W        = 34;
  localparam int ENT_DATA_LSB = 0;
  localparam int ENT_OFF_LSB  = 16;
  localparam int ENT_LB       = 32;
  localparam int ENT_UB       = 33;

  // Byte position inside a frame; the last member is FRAME_BYTES-1.
  typedef enum logic [2:0] {
    IDX_HDR    = 3'd0,
    IDX_OFF_HI = 3'd1,
    IDX_OFF_LO = 3'd2,
    IDX_DAT_HI = 3'd3,
    IDX_DAT_LO = 3'd4
  } frame_idx_e;

  function automatic logic [ENT_W-1:0] pack_entry(input logic ub, input logic lb,
                                                  input logic [15:0] off,
                                                  input logic [15:0] data);
    return {ub, lb, off, data};
  endfunction

endpackage

// File: rtl/picovid_capture_if.sv
// 68k bus snoop inputs plus the Pico link control/status signals.
// Link handshake: PICO_AVAIL high means a frame byte is presented; each rising PICO_STRB consumes it.
interface picovid_capture_if;
  import picovid_pkg::*;

  logic        AS;
  logic        UDS;
  logic        LDS;
  logic        RW;
  logic [2:0]  FC;
  logic [23:1] A;
  logic [15:0] D;
  logic        PICO_STRB;
  logic        PICO_OE_N;
  logic        PICO_AVAIL;
  logic        OVF;
  frame_idx_e  dbg_idx;

  modport master (
    output AS, UDS, LDS, RW, FC, A, D, PICO_STRB, PICO_OE_N,
    input  PICO_AVAIL, OVF, dbg_idx
  );

  modport slave (
    input  AS, UDS, LDS, RW, FC, A, D, PICO_STRB, PICO_OE_N,
    output PICO_AVAIL, OVF, dbg_idx
  );
endinterface

// File: rtl/picovid_fifo.sv
// Single-clock FIFO with combinational head read; a pop frees the slot a same-cycle push needs.
module picovid_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/picovid_capture.sv
// Snoops 68k writes into the video window, queues them and serves each as a 5-byte frame
// on the Pico link, one byte per synchronised rising edge of PICO_STRB.
module picovid_capture #(
  parameter logic [6:0] WIN_BASE = picovid_pkg::DEF_WIN_BASE,
  parameter logic [3:0] HDR_TAG  = picovid_pkg::HDR_TAG,
  parameter int         DEPTH    = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  picovid_capture_if.slave    bus,
  output wire  [7:0]          PICO_D
);
  import picovid_pkg::*;

  logic        as_r, uds_r, lds_r, rw_r;
  logic [2:0]  fc_r;
  logic [23:1] a_r;
  logic [15:0] d_r;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      as_r  <= 1'b1;
      uds_r <= 1'b1;
      lds_r <= 1'b1;
      rw_r  <= 1'b1;
      fc_r  <= '0;
      a_r   <= '0;
      d_r   <= '0;
    end else begin
      as_r  <= bus.AS;
      uds_r <= bus.UDS;
      lds_r <= bus.LDS;
      rw_r  <= bus.RW;
      fc_r  <= bus.FC;
      a_r   <= bus.A;
      d_r   <= bus.D;
    end
  end

  // s3 is the edge flop: adv marks a 0->1 transition seen at the synchroniser output.
  logic s1, s2, s3;
  logic adv;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.PICO_STRB;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign adv = s2 && !s3;

  logic             arm;
  logic             capture;
  logic             push, pop, drop, step;
  logic             full, empty;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] din;
  frame_idx_e       idx;
  logic             ovf;
  logic             avail;

  assign capture = arm && !as_r && !rw_r && (!uds_r || !lds_r) &&
                   (a_r[23:17] == WIN_BASE) && (fc_r != 3'b111);
  assign din     = pack_entry(!uds_r, !lds_r, a_r[16:1], d_r);
  assign step    = adv && !empty;
  assign pop     = step && (idx == IDX_DAT_LO);
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  picovid_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Frame sequencer; OVF is cleared when its carrying header is consumed, but a drop wins.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      idx   <= IDX_HDR;
      ovf   <= 1'b0;
      avail <= 1'b0;
      arm   <= 1'b1;
    end else begin
      avail <= !empty;
      if (capture)   arm <= 1'b0;
      else if (as_r) arm <= 1'b1;
      if (step) begin
        case (idx)
          IDX_HDR:    idx <= IDX_OFF_HI;
          IDX_OFF_HI: idx <= IDX_OFF_LO;
          IDX_OFF_LO: idx <= IDX_DAT_HI;
          IDX_DAT_HI: idx <= IDX_DAT_LO;
          default:    idx <= IDX_HDR;
        endcase
      end
      if (drop)                           ovf <= 1'b1;
      else if (step && (idx == IDX_HDR))  ovf <= 1'b0;
    end
  end

  logic [7:0] byte_val;

  always_comb begin
    byte_val = 8'h00;
    if (!empty) begin
      case (idx)
        IDX_HDR:    byte_val = {HDR_TAG, ovf, 1'b0, head[ENT_UB], head[ENT_LB]};
        IDX_OFF_HI: byte_val = head[ENT_OFF_LSB+8 +: 8];
        IDX_OFF_LO: byte_val = head[ENT_OFF_LSB +: 8];
        IDX_DAT_HI: byte_val = head[ENT_DATA_LSB+8 +: 8];
        IDX_DAT_LO: byte_val = head[ENT_DATA_LSB +: 8];
        default:    byte_val = 8'h00;
      endcase
    end
  end

  assign PICO_D         = bus.PICO_OE_N ? 8'hzz : byte_val;
  assign bus.PICO_AVAIL = avail;
  assign bus.OVF        = ovf;
  assign bus.dbg_idx    = idx;
endmodule

// File: tb/tb_picovid_capture.sv
// Bench for picovid_capture: directed frame scenarios plus concurrent random bus/strobe traffic,
// checked every cycle against a queue-based model of the captured-write stream.
module tb_picovid_capture;
  import picovid_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 34;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  picovid_capture_if bus ();
  wire [7:0] pico_d;

  picovid_capture #(
    .WIN_BASE (7'h70),
    .HDR_TAG  (4'hA),
    .DEPTH    (DEPTH)
  ) dut (
    .CLK    (clk),
    .RESET  (rst_n),
    .bus    (bus),
    .PICO_D (pico_d)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %02h want %02h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Writes land in the queue one clock after the bus sample; a strobe rise takes effect
  // on the third clock edge that sees it.
  logic [W-1:0] exp_q[$];
  int           m_idx;
  bit           m_ovf, m_arm, m_avail;
  bit           p_as, p_uds, p_lds, p_rw;
  bit [2:0]     p_fc;
  bit [23:1]    p_a;
  bit [15:0]    p_d;
  bit           hist[3];

  function automatic logic [7:0] frame_byte(input logic [W-1:0] e, input int i, input bit ovf);
    logic [15:0] off;
    logic [15:0] dat;
    off = e[31:16];
    dat = e[15:0];
    case (i)
      0:       return {4'hA, ovf, 1'b0, e[33], e[32]};
      1:       return off[15:8];
      2:       return off[7:0];
      3:       return dat[15:8];
      default: return dat[7:0];
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit cap, adv, nonempty, step, popping, drop;
    if (!rst_n) begin
      exp_q.delete();
      m_idx = 0; m_ovf = 0; m_arm = 1; m_avail = 0;
      p_as = 1; p_uds = 1; p_lds = 1; p_rw = 1; p_fc = 0; p_a = 0; p_d = 0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
    end else begin
      cap      = m_arm && !p_as && !p_rw && (!p_uds || !p_lds) &&
                 (p_a[23:17] == 7'h70) && (p_fc != 3'd7);
      adv      = hist[1] && !hist[2];
      nonempty = exp_q.size() > 0;
      step     = adv && nonempty;
      popping  = step && (m_idx == 4);
      drop     = cap && (exp_q.size() == DEPTH) && !popping;
      if (step && m_idx == 0) m_ovf = 0;
      if (drop)               m_ovf = 1;
      if (popping) begin
        void'(exp_q.pop_front());
        m_idx = 0;
      end else if (step) begin
        m_idx++;
      end
      if (cap && !drop) exp_q.push_back({~p_uds, ~p_lds, p_a[16:1], p_d});
      if (cap)       m_arm = 0;
      else if (p_as) m_arm = 1;
      m_avail = nonempty;
      p_as = bus.AS; p_uds = bus.UDS; p_lds = bus.LDS; p_rw = bus.RW;
      p_fc = bus.FC; p_a = bus.A; p_d = bus.D;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = bus.PICO_STRB;
    end
  end

  // ---------------- per-cycle scoreboard compare ----------------
  always @(negedge clk) begin
    logic [7:0] want;
    want = (exp_q.size() > 0) ? frame_byte(exp_q[0], m_idx, m_ovf) : 8'h00;
    check("avail", {7'd0, bus.PICO_AVAIL}, {7'd0, m_avail});
    check("ovf",   {7'd0, bus.OVF},        {7'd0, m_ovf});
    if (!bus.PICO_OE_N) check("pico_d", pico_d, want);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic [23:0] addr, input logic [15:0] data, input bit uds,
                           input bit lds, input bit rw, input logic [2:0] fc, input int hold);
    bus.A = addr[23:1]; bus.D = data; bus.FC = fc; bus.RW = rw;
    bus.AS = 0; bus.UDS = uds; bus.LDS = lds;
    repeat (hold) tick();
    bus.AS = 1; bus.UDS = 1; bus.LDS = 1; bus.RW = 1;
    repeat (2) tick();
  endtask

  task automatic strobe_byte();
    bus.PICO_STRB = 1;
    repeat (5) tick();
    bus.PICO_STRB = 0;
    repeat (5) tick();
  endtask

  task automatic read_frame(input string name, input logic [39:0] bytes);
    logic [39:0] b;
    b = bytes;
    for (int i = 0; i < 5; i++) begin
      check(name, pico_d, b[39-8*i -: 8]);
      strobe_byte();
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    repeat (2) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.AS = 1; bus.UDS = 1; bus.LDS = 1; bus.RW = 1; bus.FC = 3'd5;
    bus.A = '0; bus.D = '0; bus.PICO_STRB = 0; bus.PICO_OE_N = 0;
    rst_n = 0;
    repeat (3) tick();
    check("rst_avail", {7'd0, bus.PICO_AVAIL}, 8'h00);
    check("rst_ovf",   {7'd0, bus.OVF},        8'h00);
    check("rst_d",     pico_d,                 8'h00);
    rst_n = 1;
    repeat (2) tick();

    // word write, full frame
    bus_cycle(24'hE01234, 16'hBEEF, 0, 0, 0, 3'd5, 2);
    tick();
    check("word_avail", {7'd0, bus.PICO_AVAIL}, 8'h01);
    read_frame("word_frame", 40'hA3091ABEEF);
    check("word_avail_fall", {7'd0, bus.PICO_AVAIL}, 8'h00);

    // lower-byte write
    bus_cycle(24'hE00010, 16'h0055, 1, 0, 0, 3'd5, 2);
    tick();
    read_frame("lds_frame", 40'hA100080055);

    // read, out-of-window, and FC=7 cycles are ignored
    bus_cycle(24'hE00020, 16'h1111, 0, 0, 1, 3'd5, 2);
    bus_cycle(24'h400000, 16'h2222, 0, 0, 0, 3'd5, 2);
    bus_cycle(24'hE00030, 16'h3333, 0, 0, 0, 3'd7, 2);
    repeat (3) tick();
    check("ignored_avail", {7'd0, bus.PICO_AVAIL}, 8'h00);

    // strobes held for 6 clocks push once
    bus_cycle(24'hE00100, 16'h1234, 0, 0, 0, 3'd1, 6);
    tick();
    check("hold_count", 8'(exp_q.size()), 8'h01);
    read_frame("hold_frame", 40'hA300801234);
    check("hold_avail", {7'd0, bus.PICO_AVAIL}, 8'h00);

    // overflow: 9 writes into 8 slots
    for (int i = 0; i < 9; i++) bus_cycle(24'hE02000 + 24'(2*i), 16'(i), 0, 0, 0, 3'd5, 2);
    tick();
    check("ovf_set", {7'd0, bus.OVF}, 8'h01);
    read_frame("ovf_frame", 40'hAB10000000);
    check("ovf_clear", {7'd0, bus.OVF}, 8'h00);
    check("ovf_next_hdr", pico_d, 8'hA3);
    repeat (35) strobe_byte();
    check("ovf_drained", {7'd0, bus.PICO_AVAIL}, 8'h00);

    // capture lands on the same edge as the pop while full
    for (int i = 0; i < 8; i++) bus_cycle(24'hE03000 + 24'(2*i), 16'hC000 + 16'(i), 0, 0, 0, 3'd5, 2);
    repeat (4) strobe_byte();
    bus.PICO_STRB = 1;
    tick();
    bus_cycle(24'hE03100, 16'hD00D, 0, 0, 0, 3'd5, 1);
    tick();
    bus.PICO_STRB = 0;
    repeat (5) tick();
    check("full_pp_ovf",   {7'd0, bus.OVF}, 8'h00);
    check("full_pp_count", 8'(exp_q.size()), 8'h08);
    repeat (35) strobe_byte();
    read_frame("full_pp_last", 40'hA31880D00D);

    // reset mid-frame
    for (int i = 0; i < 3; i++) bus_cycle(24'hE04000 + 24'(2*i), 16'h5A00 + 16'(i), 0, 0, 0, 3'd5, 2);
    repeat (2) strobe_byte();
    rst_n = 0;
    tick();
    check("midrst_avail", {7'd0, bus.PICO_AVAIL}, 8'h00);
    check("midrst_d",     pico_d,                 8'h00);
    check("midrst_ovf",   {7'd0, bus.OVF},        8'h00);
    rst_n = 1;
    tick();
    bus_cycle(24'hE00040, 16'h7777, 0, 1, 0, 3'd5, 2);
    tick();
    read_frame("post_rst_frame", 40'hA200207777);

    // random traffic: bus writes and Pico strobes run concurrently
    fork
      begin
        for (int n = 0; n < 70; n++) begin
          logic [31:0] r;
          logic [23:0] ad;
          r  = $urandom();
          ad = r[23:0];
          if ($urandom_range(0, 9) < 7) ad[23:17] = 7'h70;
          bus_cycle(ad, 16'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)), $urandom_range(1, 4));
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        for (int n = 0; n < 60; n++) begin
          bus.PICO_OE_N = ($urandom_range(0, 7) == 0);
          bus.PICO_STRB = 1;
          repeat ($urandom_range(4, 7)) tick();
          bus.PICO_STRB = 0;
          repeat ($urandom_range(4, 7)) tick();
        end
      end
    join
    bus.PICO_OE_N = 0;
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) strobe_byte();
    repeat (3) tick();
    check("final_drain", {7'd0, bus.PICO_AVAIL}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
